dp_elastic: RTL and testbench
=============================

// Module: dp_elastic
//
// PURPOSE
// N-stage elastic datapath pipeline with valid/ready flow control on both ends.
// Each stage advances independently, so empty stages (bubbles) are squeezed out under backpressure.
// Adds a synchronous flush and occupancy status.
// Sits between producer/consumer blocks that need N cycles of retiming but cannot tolerate a global stall.
//
// PARAMETERS
// W   32  payload width in bits (>=1)
// N   4   number of stages (>=1; N==0 is an elaboration error)
// localparam CW = $clog2(N+1), the occupancy counter width
//
// PORTS
// clk          in   1      clock
// srst         in   1      reset, synchronous, active-high
// in_vld_i     in   1      input payload valid
// in_dat_i     in   W      input payload
// in_rdy_o     out  1      pipeline accepts input this cycle
// out_vld_o    out  1      stage N holds valid payload
// out_dat_o    out  W      stage N payload
// out_rdy_i    in   1      consumer accepts output this cycle
// flush_i      in   1      discard all in-flight payloads
// pipe_vld_o   out  N      per-stage valid, bit k-1 = stage k
// pipe_dat_o   out  N*W    per-stage payload, slice k-1 = stage k
// occ_o        out  CW     number of valid stages
// empty_o      out  1      occ_o == 0
// full_o       out  1      occ_o == N
//
// BEHAVIOUR
// - Clock and reset: one clock. Reset is synchronous and active-high.
// - Advance chain (combinational):
//   adv[N] = ~vld[N] | out_rdy_i;  adv[k] = ~vld[k] | adv[k+1].
//   in_rdy_o = adv[1] & ~flush_i & ~srst.
//   The comb path out_rdy_i -> in_rdy_o is intentional.
// - Fire conditions: in_fire = in_vld_i & in_rdy_o; out_fire = out_vld_o & out_rdy_i.
// - Valid update: when adv[k], vld[k] <= src_vld.
//   src_vld for k==1 is in_vld_i & ~flush_i; otherwise it is vld[k-1].
// - Data enable: stage k data loads only when adv[k] & src_vld. Data is held otherwise (no bubble toggling).
// - Ordering and rates: payloads leave in acceptance order; none is lost or duplicated.
//   Throughput is 1 per cycle. Min latency is N: accepted at edge t, out_vld_o high in cycle t+N.
// - Output stability: while out_vld_o & ~out_rdy_i, out_dat_o is stable and out_vld_o stays high.
// - Under backpressure: input keeps being accepted until all N stages are valid, then in_rdy_o=0.
// - Occupancy: occ_o is registered, occ <= occ + in_fire - out_fire.
//   Simultaneous in_fire & out_fire when full is legal and holds occ at N.
//   occ_o must always equal popcount(pipe_vld_o).
// - flush_i (sync): in the flush cycle in_rdy_o=0 and input is dropped.
//   An out_fire in that cycle completes normally.
//   Next cycle all vld=0 and occ_o=0. Data registers are untouched.
// - srst: in the following cycle all vld=0, occ_o=0, out_vld_o=0, empty_o=1, full_o=0.
//   in_rdy_o=0 while srst is high and returns to 1 the cycle after.
//   Data registers are not reset; pipe_dat_o is X-tolerant until first load.
//   srst mid-stream discards all in-flight payloads; srst dominates flush_i.
// - in_dat_i is ignored when in_vld_i=0. out_dat_o is meaningless when out_vld_o=0.
// - N==1: adv[1] = ~vld[1] | out_rdy_i. Same rules apply, latency 1.
//
// TESTING (N=4, W=8)
// 1. Push 0..7 back-to-back, out_rdy_i=1 -> out 0..7 on consecutive cycles, each 4 cycles after accept; occ_o steady 4.
// 2. out_rdy_i=0, push 0..5 -> exactly 0..3 accepted, in_rdy_o=0 and full_o=1 after 4th.
//    Then raise out_rdy_i -> 0,1,2,3,4,5 emerge 1/cycle in order.
// 3. Push A, 2 idle cycles, push B, out_rdy_i=0 -> A at stage 4, B collapses to stage 3;
//    pipe_vld_o=4'b1100, occ_o=2.
// 4. 3 items in flight, assert flush_i with in_vld_i=1 -> next cycle occ_o=0, out_vld_o=0;
//    nothing emerges in the following 10 cycles.
// 5. srst for 1 cycle mid-stream (occ_o=3) -> next cycle all valids 0;
//    a push of 0x5A afterwards emerges exactly 4 cycles later.
// 6. 10k cycles of random in_vld_i/out_rdy_i/rare flush_i vs scoreboard queue ->
//    no mismatch; occ_o==popcount(pipe_vld_o) every cycle.

Source files
------------

// File: rtl/dp_elastic.sv
// Elastic N-stage valid/ready pipeline. Each stage advances on its own, so
// bubbles are squeezed out under backpressure. Adds sync flush and occupancy.

module dp_elastic_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         i_srst,
  input  logic         i_flush,
  input  logic         i_adv,
  input  logic         i_src_vld,
  input  logic [W-1:0] i_src_dat,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);

  logic         r_vld;
  logic [W-1:0] r_dat;

  always_ff @(posedge clk) begin
    if (i_srst || i_flush) r_vld <= 1'b0;
    else if (i_adv)        r_vld <= i_src_vld;
  end

  // Data only moves with a real payload, and a flush leaves it untouched.
  always_ff @(posedge clk) begin
    if (i_adv && i_src_vld && !i_flush) r_dat <= i_src_dat;
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

module dp_elastic #(
  parameter  int W  = 32,
  parameter  int N  = 4,
  localparam int CW = $clog2(N+1)
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            in_vld_i,
  input  logic [W-1:0]    in_dat_i,
  output logic            in_rdy_o,
  output logic            out_vld_o,
  output logic [W-1:0]    out_dat_o,
  input  logic            out_rdy_i,
  input  logic            flush_i,
  output logic [N-1:0]    pipe_vld_o,
  output logic [N*W-1:0]  pipe_dat_o,
  output logic [CW-1:0]   occ_o,
  output logic            empty_o,
  output logic            full_o
);

  if (N < 1) begin : g_bad_n
    $error("dp_elastic: N must be >= 1");
  end

  logic [N-1:0]         w_vld;
  logic [N-1:0]         w_adv;
  logic [N-1:0]         w_src_vld;
  logic [N-1:0][W-1:0]  w_dat;
  logic [N-1:0][W-1:0]  w_src_dat;
  logic                 w_in_fire;
  logic                 w_out_fire;
  logic [CW-1:0]        r_occ;

  // Index k-1 holds stage k. A stage can advance unless it and every stage
  // downstream of it is full and the consumer stalls.
  for (genvar k = 0; k < N; k++) begin : g_stage
    assign w_adv[k] = out_rdy_i | ~(&w_vld[N-1:k]);

    if (k == 0) begin : g_head
      assign w_src_vld[k] = in_vld_i & ~flush_i;
      assign w_src_dat[k] = in_dat_i;
    end else begin : g_body
      assign w_src_vld[k] = w_vld[k-1];
      assign w_src_dat[k] = w_dat[k-1];
    end

    dp_elastic_stage #(.W(W)) u_stage (
      .clk       (clk),
      .i_srst    (srst),
      .i_flush   (flush_i),
      .i_adv     (w_adv[k]),
      .i_src_vld (w_src_vld[k]),
      .i_src_dat (w_src_dat[k]),
      .o_vld     (w_vld[k]),
      .o_dat     (w_dat[k])
    );
  end

  assign in_rdy_o   = w_adv[0] & ~flush_i & ~srst;
  assign out_vld_o  = w_vld[N-1];
  assign out_dat_o  = w_dat[N-1];
  assign w_in_fire  = in_vld_i & in_rdy_o;
  assign w_out_fire = out_vld_o & out_rdy_i;

  always_ff @(posedge clk) begin
    if (srst || flush_i) r_occ <= '0;
    else                 r_occ <= r_occ + CW'(w_in_fire) - CW'(w_out_fire);
  end

  assign pipe_vld_o = w_vld;
  assign pipe_dat_o = w_dat;
  assign occ_o      = r_occ;
  assign empty_o    = (r_occ == '0);
  assign full_o     = (r_occ == CW'(N));

endmodule

// File: tb/tb_dp_elastic.sv
// Directed + randomized checks of dp_elastic at N=4, W=8.

module tb_dp_elastic;

  logic        clk = 1'b0;
  logic        srst, in_vld, in_rdy, out_vld, out_rdy, flush, empty, full;
  logic [7:0]  in_dat, out_dat;
  logic [3:0]  pipe_vld;
  logic [31:0] pipe_dat;
  logic [2:0]  occ;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  q[$];

  always #5 clk = ~clk;

  dp_elastic #(.W(8), .N(4)) dut (
    .clk        (clk),
    .srst       (srst),
    .in_vld_i   (in_vld),
    .in_dat_i   (in_dat),
    .in_rdy_o   (in_rdy),
    .out_vld_o  (out_vld),
    .out_dat_o  (out_dat),
    .out_rdy_i  (out_rdy),
    .flush_i    (flush),
    .pipe_vld_o (pipe_vld),
    .pipe_dat_o (pipe_dat),
    .occ_o      (occ),
    .empty_o    (empty),
    .full_o     (full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    srst = 1'b1; in_vld = 1'b0; in_dat = 8'h00; out_rdy = 1'b0; flush = 1'b0;
    #1;
    chk("rst_rdy_low", in_rdy, 0);
    tick();
    chk("rst_rdy_low2", in_rdy, 0);
    srst = 1'b0;
    #1;
    chk("rst_occ", occ, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovld", out_vld, 0);
    chk("rst_pvld", pipe_vld, 0);
    chk("rst_rdy_back", in_rdy, 1);

    // 1: streaming, 4-cycle latency, occupancy settles at 4
    out_rdy = 1'b1;
    for (int c = 0; c < 13; c++) begin
      in_vld = (c < 8);
      in_dat = 8'(c);
      #1;
      chk("t1_ovld", out_vld, (c >= 4 && c < 12));
      if (c >= 4 && c < 12) chk("t1_odat", out_dat, c - 4);
      chk("t1_occ", occ, ((c < 8) ? c : 8) - ((c > 4) ? c - 4 : 0));
      if (c < 8) chk("t1_rdy", in_rdy, 1);
      tick();
    end

    // 2: backpressure fills exactly 4, then drains in order
    out_rdy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_vld = 1'b1;
      in_dat = 8'((c < 4) ? c : 4);
      #1;
      chk("t2_rdy", in_rdy, (c < 4));
      chk("t2_full", full, (c >= 4));
      chk("t2_occ", occ, (c < 4) ? c : 4);
      tick();
    end
    out_rdy = 1'b1;
    for (int d = 0; d < 7; d++) begin
      in_vld = (d < 2);
      in_dat = 8'(4 + d);
      #1;
      if (d < 6) begin
        chk("t2_ovld", out_vld, 1);
        chk("t2_odat", out_dat, d);
      end else begin
        chk("t2_ovld_end", out_vld, 0);
        chk("t2_empty", empty, 1);
      end
      if (d < 2) chk("t2_rdy_comb", in_rdy, 1);
      tick();
    end

    // 3: bubble collapse under stall
    out_rdy = 1'b0;
    in_vld = 1'b1; in_dat = 8'hA1;
    tick();
    in_vld = 1'b0;
    tick();
    tick();
    in_vld = 1'b1; in_dat = 8'hB2;
    tick();
    in_vld = 1'b0;
    tick();
    tick();
    tick();
    #1;
    chk("t3_pvld", pipe_vld, 4'b1100);
    chk("t3_occ", occ, 2);
    chk("t3_ovld", out_vld, 1);
    chk("t3_odat", out_dat, 8'hA1);
    chk("t3_s3dat", pipe_dat[23:16], 8'hB2);
    out_rdy = 1'b1;
    #1;
    chk("t3_outA", out_dat, 8'hA1);
    tick();
    chk("t3_ovldB", out_vld, 1);
    chk("t3_outB", out_dat, 8'hB2);
    tick();
    chk("t3_empty", empty, 1);

    // 4: flush with 3 in flight drops everything, including the input offered
    for (int c = 0; c < 3; c++) begin
      in_vld = 1'b1; in_dat = 8'(8'h11 * (c + 1));
      tick();
    end
    in_vld = 1'b1; in_dat = 8'h44; flush = 1'b1;
    #1;
    chk("t4_occ_pre", occ, 3);
    chk("t4_rdy_flush", in_rdy, 0);
    tick();
    flush = 1'b0; in_vld = 1'b0;
    #1;
    chk("t4_occ", occ, 0);
    chk("t4_ovld", out_vld, 0);
    chk("t4_pvld", pipe_vld, 0);
    chk("t4_empty", empty, 1);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t4_quiet", out_vld, 0);
    end

    // 5: srst mid-stream (dominating flush), then 0x5A has latency 4
    for (int c = 0; c < 3; c++) begin
      in_vld = 1'b1; in_dat = 8'(8'h61 + c);
      tick();
    end
    chk("t5_occ_pre", occ, 3);
    srst = 1'b1; flush = 1'b1; in_vld = 1'b1; in_dat = 8'h64;
    #1;
    chk("t5_rdy_srst", in_rdy, 0);
    tick();
    srst = 1'b0; flush = 1'b0; in_vld = 1'b1; in_dat = 8'h5A;
    #1;
    chk("t5_pvld", pipe_vld, 0);
    chk("t5_occ", occ, 0);
    chk("t5_ovld", out_vld, 0);
    chk("t5_empty", empty, 1);
    chk("t5_full", full, 0);
    chk("t5_rdy", in_rdy, 1);
    tick();
    in_vld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("t5_lat", out_vld, (k == 4));
      if (k == 4) chk("t5_odat", out_dat, 8'h5A);
      tick();
    end

    // 6: random traffic against a scoreboard queue
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic exp_rdy;
      in_vld  = ($urandom_range(0, 3) != 0);
      in_dat  = 8'($urandom);
      out_rdy = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 99) == 0);
      #1;
      exp_rdy = ~flush & (out_rdy | (q.size() < 4));
      chk("rnd_occ_pop", occ, $countones(pipe_vld));
      chk("rnd_occ_sb", occ, q.size());
      chk("rnd_rdy", in_rdy, exp_rdy);
      if (out_vld && out_rdy) begin
        if (q.size() == 0) chk("rnd_unexpected_out", 1, 0);
        else chk("rnd_odat", out_dat, q.pop_front());
      end
      if (flush) q.delete();
      else if (in_vld && exp_rdy) q.push_back(in_dat);
      tick();
    end
    flush = 1'b0; in_vld = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
